// File: rtl/lock_pkg.sv
// lock_pkg: shared types and constants for the lock supervisor and the digital_lock core.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    PREP,
    PLAY,
    CHECK,
    OPEN,
    LOCKOUT
  } sup_state_t;

  // digital_lock core state encoding; lock_y is high only in S3.
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } core_state_t;

  // Driving this for one edge returns the core to S0.
  localparam logic [2:0] LOCK_CLEAR = 3'b000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_sup_timer.sv
// lock_sup_timer: loadable down-counter that stops at zero; shared by the open,
// lockout and entry-timeout intervals.
module lock_sup_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lock_supervisor.sv
// lock_supervisor: buffers a 3-digit keypad entry, replays it into the digital_lock core
// from S0 and applies unlock / failure / lockout policy. Entry timeout: LOCK_SUP_TIMEOUT_EN.
module lock_supervisor
  import lock_pkg::*;
#(
  parameter int MAX_FAILS      = 3,
  parameter int OPEN_CYCLES    = 500,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [2:0] key_code,
  output logic       key_ready,
  output logic [2:0] lock_x,
  input  logic       lock_y,
  input  logic [1:0] lock_state,
  output logic       unlock,
  output logic       alarm,
  output logic [3:0] fail_cnt
);

  localparam int TW = $clog2(max3(OPEN_CYCLES, LOCKOUT_CYCLES, TIMEOUT_CYCLES)) + 1;

  sup_state_t    state, next;
  logic [2:0]    digits [3];
  logic [1:0]    cnt;
  logic [1:0]    play_idx;
  logic          accept;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;

  // Transfer happens on key_valid & key_ready at a rising edge; ready is a pure state decode.
  assign key_ready = (state == IDLE) || (state == ENTRY);
  assign accept    = key_valid && key_ready;

  lock_sup_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    next     = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          next = ENTRY;
`ifdef LOCK_SUP_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = TW'(TIMEOUT_CYCLES);
`endif
        end
      end
      ENTRY: begin
        if (accept) begin
          if (cnt == 2'd2) next = PREP;
`ifdef LOCK_SUP_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = TW'(TIMEOUT_CYCLES);
        end else if (tmr_zero) begin
          next = IDLE;
`endif
        end
      end
      PREP: next = PLAY;
      PLAY: begin
        if (play_idx == 2'd2) next = CHECK;
      end
      CHECK: begin
        if (lock_y) begin
          next     = OPEN;
          tmr_load = 1'b1;
          tmr_val  = TW'(OPEN_CYCLES - 1);
        end else if (int'(fail_cnt) + 1 < MAX_FAILS) begin
          next = IDLE;
        end else begin
          next     = LOCKOUT;
          tmr_load = 1'b1;
          tmr_val  = TW'(LOCKOUT_CYCLES - 1);
        end
      end
      OPEN, LOCKOUT: begin
        if (tmr_zero) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      play_idx  <= 2'd0;
      fail_cnt  <= 4'd0;
      lock_x    <= LOCK_CLEAR;
      unlock    <= 1'b0;
      alarm     <= 1'b0;
      digits[0] <= 3'd0;
      digits[1] <= 3'd0;
      digits[2] <= 3'd0;
    end else begin
      state  <= next;
      unlock <= (next == OPEN);
      alarm  <= (next == LOCKOUT);
      lock_x <= LOCK_CLEAR;
      case (state)
        IDLE: begin
          if (accept) begin
            digits[0] <= key_code;
            cnt       <= 2'd1;
          end
        end
        ENTRY: begin
          if (accept) begin
            if (cnt == 2'd1) digits[1] <= key_code;
            else             digits[2] <= key_code;
            cnt <= cnt + 2'd1;
          end else if (next == IDLE) begin
            cnt <= 2'd0;
          end
        end
        PREP: begin
          cnt      <= 2'd0;
          play_idx <= 2'd0;
          lock_x   <= digits[0];
        end
        PLAY: begin
          if (play_idx != 2'd2) begin
            play_idx <= play_idx + 2'd1;
            lock_x   <= (play_idx == 2'd0) ? digits[1] : digits[2];
          end
        end
        CHECK: begin
          if (lock_y)                 fail_cnt <= 4'd0;
          else if (next == LOCKOUT)   fail_cnt <= 4'(MAX_FAILS);
          else                        fail_cnt <= fail_cnt + 4'd1;
        end
        LOCKOUT: begin
          if (next == IDLE) fail_cnt <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  // The core's reported state must agree with its unlock flag whenever we sample it.
  lock_y_consistent: assert property (@(posedge clk) disable iff (reset)
    (state == CHECK) |-> (lock_y == (core_state_t'(lock_state) == S3)));

endmodule
